// File: rtl/ex_div_unit.sv
// Iterative RV64 divider for the EX stage (DIV/DIVU/REM/REMU and W forms).
// Define DIV_RADIX4_EN to retire two quotient bits per cycle instead of one.
module ex_div_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req,
  input  logic [1:0]      div_op,
  input  logic            div_word,
  input  logic [XLEN-1:0] div_a,
  input  logic [XLEN-1:0] div_b,
  input  logic            stall_ex,
  input  logic            flush,
  output logic            ex_stall_req,
  output logic [XLEN-1:0] div_result,
  output logic            div_valid,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef DIV_RADIX4_EN
  localparam int N_D = 32;
  localparam int N_W = 16;
`else
  localparam int N_D = 64;
  localparam int N_W = 32;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*XLEN:0] div_step(input logic [XLEN:0] r,
                                               input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] d);
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
    sh   = {r[XLEN-1:0], q[XLEN-1]};
    diff = sh - {1'b0, d};
    if (!diff[XLEN]) return {diff, q[XLEN-2:0], 1'b1};
    return {sh, q[XLEN-2:0], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] fix_up(input logic [XLEN-1:0] q,
                                             input logic [XLEN-1:0] r,
                                             input logic w, input logic rem,
                                             input logic nq, input logic nr);
    logic [XLEN-1:0] qs;
    logic [XLEN-1:0] rs;
    logic [31:0]     sel32;
    qs    = nq ? (~q + XLEN'(1)) : q;
    rs    = nr ? (~r + XLEN'(1)) : r;
    sel32 = rem ? rs[31:0] : qs[31:0];
    if (w) return {{(XLEN-32){sel32[31]}}, sel32};
    return rem ? rs : qs;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            is_rem_q, is_rem_d;
  logic            word_q, word_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed, a_sgn, b_sgn, b_zero, ovf, start;
  logic [31:0]     a_lo_mag, b_lo_mag;
  logic [XLEN-1:0] a_mag, b_mag, sext_a, special_res;
  logic [2*XLEN:0] step1, step2;

  assign is_signed = ~div_op[0];
  assign a_sgn     = is_signed & (div_word ? div_a[31] : div_a[XLEN-1]);
  assign b_sgn     = is_signed & (div_word ? div_b[31] : div_b[XLEN-1]);
  assign a_lo_mag  = a_sgn ? (~div_a[31:0] + 32'd1) : div_a[31:0];
  assign b_lo_mag  = b_sgn ? (~div_b[31:0] + 32'd1) : div_b[31:0];
  assign a_mag     = div_word ? {{(XLEN-32){1'b0}}, a_lo_mag}
                              : (a_sgn ? (~div_a + XLEN'(1)) : div_a);
  assign b_mag     = div_word ? {{(XLEN-32){1'b0}}, b_lo_mag}
                              : (b_sgn ? (~div_b + XLEN'(1)) : div_b);
  assign sext_a    = div_word ? {{(XLEN-32){div_a[31]}}, div_a[31:0]} : div_a;

  assign b_zero = div_word ? (div_b[31:0] == 32'd0) : (div_b == '0);
  assign ovf    = is_signed &
                  (div_word ? ((div_a[31:0] == 32'h8000_0000) && (div_b[31:0] == 32'hFFFF_FFFF))
                            : ((div_a == {1'b1, {(XLEN-1){1'b0}}}) && (div_b == '1)));
  assign special_res = b_zero ? (div_op[1] ? sext_a : '1)
                              : (div_op[1] ? '0 : sext_a);

  assign start = div_req & ~flush;

  // Handshake: div_req acts as valid for the EX instruction; in DONE the
  // result is held until ~stall_ex (ready), and the instruction leaves EX on
  // that same edge, so it never restarts the divider.
  assign ex_stall_req = ~rst & ~flush &
                        (((state_q == S_IDLE) & div_req) | (state_q == S_CALC));
  assign div_valid    = (state_q == S_DONE);
  assign div_result   = result_q;
  assign dbg_state    = state_q;

  assign step1 = div_step(rem_q, quo_q, dvsr_q);
`ifdef DIV_RADIX4_EN
  assign step2 = div_step(step1[2*XLEN:XLEN], step1[XLEN-1:0], dvsr_q);
`else
  assign step2 = step1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    is_rem_d = is_rem_q;
    word_d   = word_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_rem_d = div_op[1];
          word_d   = div_word;
          neg_q_d  = a_sgn ^ b_sgn;
          neg_r_d  = a_sgn;
          if (b_zero || ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            // W operands sit in the top half so the MSB-first shift sees them first.
            quo_d   = div_word ? {a_mag[31:0], 32'd0} : a_mag;
            dvsr_d  = b_mag;
            cnt_d   = div_word ? CNT_W'(N_W) : CNT_W'(N_D);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step2[2*XLEN:XLEN];
        quo_d = step2[XLEN-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = fix_up(step2[XLEN-1:0], step2[2*XLEN-1:XLEN],
                            word_q, is_rem_q, neg_q_q, neg_r_q);
        end
      end
      S_DONE: begin
        if (!stall_ex) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
      word_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      is_rem_q <= is_rem_d;
      word_q   <= word_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: latency, stall/hold, flush, reset and result scoreboard.
module tb_ex_div_unit;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_RADIX4_EN
  localparam int N_D = 32;
  localparam int N_W = 16;
`else
  localparam int N_D = 64;
  localparam int N_W = 32;
`endif
  localparam int LAT_D = N_D + 1;
  localparam int LAT_W = N_W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req;
  logic [1:0]  div_op;
  logic        div_word;
  logic [63:0] div_a;
  logic [63:0] div_b;
  logic        stall_ex;
  logic        flush;
  logic        ex_stall_req;
  logic [63:0] div_result;
  logic        div_valid;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_div_unit dut (
    .clk(clk), .rst(rst), .div_req(div_req), .div_op(div_op), .div_word(div_word),
    .div_a(div_a), .div_b(div_b), .stall_ex(stall_ex), .flush(flush),
    .ex_stall_req(ex_stall_req), .div_result(div_result), .div_valid(div_valid),
    .dbg_state(dbg_state)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference result built from the language's own division operators.
  function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic sgn, rem;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    sgn = ~op[0];
    rem = op[1];
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
      else if (sgn && rem) r32 = $signed(a32) % $signed(b32);
      else if (sgn) r32 = $signed(a32) / $signed(b32);
      else if (rem) r32 = a32 % b32;
      else r32 = a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0) r64 = rem ? a : '1;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r64 = rem ? 64'd0 : a;
    else if (sgn && rem) r64 = $signed(a) % $signed(b);
    else if (sgn) r64 = $signed(a) / $signed(b);
    else if (rem) r64 = a % b;
    else r64 = a / b;
    return r64;
  endfunction

  task automatic do_div(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat,
                        input int hold);
    int cyc;
    int stalls;
    logic [63:0] e;
    @(negedge clk);
    exp_q.push_back(exp);
    div_req = 1'b1; div_op = op; div_word = w; div_a = a; div_b = b; stall_ex = 1'b0;
    cyc = 0;
    stalls = 0;
    #1;
    while (!div_valid && cyc < 300) begin
      if (ex_stall_req) stalls++;
      stall_ex = ex_stall_req;
      @(negedge clk);
      #1;
      cyc++;
    end
    stall_ex = (hold > 0);
    check_val("latency", 64'(cyc), 64'(lat));
    check_val("stall_cycles", 64'(stalls), 64'(lat));
    check_val("stall_in_done", {63'd0, ex_stall_req}, 64'd0);
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 64'd1, 64'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_val("result", div_result, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check_val("hold_valid", {63'd0, div_valid}, 64'd1);
      check_val("hold_result", div_result, e);
    end
    stall_ex = 1'b0;
    @(negedge clk);
    div_req = 1'b0;
    #1;
    check_val("exit_valid", {63'd0, div_valid}, 64'd0);
    check_val("exit_stall", {63'd0, ex_stall_req}, 64'd0);
    check_val("exit_state", {62'd0, dbg_state}, 64'd0);
  endtask

  task automatic do_model(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
    logic bz, ov, sgn;
    int lat;
    sgn = ~op[0];
    bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    : (a == 64'h8000_0000_0000_0000 && b == '1));
    lat = (bz || ov) ? 1 : (w ? LAT_W : LAT_D);
    do_div(op, w, a, b, model(op, w, a, b), lat, 0);
  endtask

  initial begin
    logic [1:0] r_op;
    logic r_w;
    logic [63:0] r_a, r_b;
    rst = 1'b1; div_req = 1'b1; div_op = OP_DIV; div_word = 1'b0;
    div_a = 64'd100; div_b = 64'd7; stall_ex = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_val("rst_stall", {63'd0, ex_stall_req}, 64'd0);
    @(negedge clk);
    div_req = 1'b0;
    rst = 1'b0;
    #1;
    check_val("rst_valid", {63'd0, div_valid}, 64'd0);
    check_val("rst_result", div_result, 64'd0);
    check_val("rst_state", {62'd0, dbg_state}, 64'd0);

    do_div(OP_DIV,  1'b0, 64'd100, 64'd7, 64'd14, LAT_D, 0);
    do_div(OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_D, 0);
    do_div(OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_div(OP_REMU, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1, 0);
    do_div(OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    do_div(OP_DIVU, 1'b0, 64'd10, 64'd3, 64'd3, LAT_D, 5);
    do_div(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    do_div(OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, LAT_D, 0);
    do_div(OP_REMW_dummy_guard(), 1'b1, 64'h0000_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFF, LAT_W, 0);

    // Flush in the middle of a divide.
    @(negedge clk);
    div_req = 1'b1; div_op = OP_DIVU; div_word = 1'b0; div_a = 64'd1000; div_b = 64'd7;
    for (int i = 0; i < 20; i++) begin
      #1;
      stall_ex = ex_stall_req;
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check_val("flush_stall", {63'd0, ex_stall_req}, 64'd0);
    @(negedge clk);
    flush = 1'b0; div_req = 1'b0; stall_ex = 1'b0;
    #1;
    check_val("flush_valid", {63'd0, div_valid}, 64'd0);
    check_val("flush_state", {62'd0, dbg_state}, 64'd0);
    check_val("flush_req", {63'd0, ex_stall_req}, 64'd0);
    do_div(OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, LAT_D, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    div_req = 1'b1; div_op = OP_DIV; div_word = 1'b0; div_a = 64'd77; div_b = 64'd5;
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_stall", {63'd0, ex_stall_req}, 64'd0);
    @(negedge clk);
    div_req = 1'b0;
    #1;
    check_val("midrst_state", {62'd0, dbg_state}, 64'd0);
    check_val("midrst_result", div_result, 64'd0);
    check_val("midrst_valid", {63'd0, div_valid}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_w  = 1'($urandom_range(0, 1));
      r_a  = {$urandom, $urandom} >> $urandom_range(0, 40);
      r_b  = {$urandom, $urandom} >> $urandom_range(0, 62);
      if ($urandom_range(0, 1) == 1) r_a = ~r_a + 64'd1;
      if ($urandom_range(0, 1) == 1) r_b = ~r_b + 64'd1;
      if (i == 9) r_b = 64'd0;
      do_model(r_op, r_w, r_a, r_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  function automatic logic [1:0] OP_REMW_dummy_guard();
    return OP_REM;
  endfunction

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative integer divider in the EX stage of the 5-stage RV64 pipeline.
- Executes DIV/DIVU/REM/REMU and their W variants.
- Raises ex_stall_req to the pipeline stall controller while a division is in progress.
- Holds its result until the EX stage is allowed to advance.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- div_req  in  1  EX holds a divide-class instruction this cycle.
- div_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- div_word  in  1  W variant: use low 32 bits, sign-extend the 32-bit result.
- div_a  in  XLEN  dividend.
- div_b  in  XLEN  divisor.
- stall_ex  in  1  stall_ctrl[3] from the stall controller; 1 = EX held this cycle.
- flush  in  1  cancel the current operation (trap/redirect).
- ex_stall_req  out  1  stall request to the stall controller; combinational.
- div_result  out  XLEN  quotient or remainder.
- div_valid  out  1  div_result valid for the instruction in EX.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, counter=0, div_result=0, div_valid=0.
  - ex_stall_req=0 while rst is high.
- State IDLE:
  - ex_stall_req = div_req & ~flush.
  - On div_req & ~flush, latch operands, op and word.
  - If either special case below applies: compute the result directly and go to DONE.
  - Otherwise: load |a| and |b| (unsigned ops use raw values), counter=N, go to CALC.
  - N = 64, or 32 when div_word=1.
- State CALC:
  - ex_stall_req=1.
  - Restoring shift-subtract, one quotient bit per cycle.
  - Counter decrements each cycle; the cycle counter reaches 0 goes to DONE.
- State DONE:
  - ex_stall_req=0, div_valid=1, div_result stable.
  - Stays in DONE while stall_ex=1 (e.g. a downstream MEM stall).
  - When stall_ex=0 the instruction leaves EX this cycle; next state IDLE, div_valid=0.
  - The same instruction never retriggers.
- Latency:
  - Request cycle = cycle 0.
  - Normal operation: ex_stall_req high for cycles 0..N; div_valid first high in cycle N+1.
  - Special case: ex_stall_req high in cycle 0 only; div_valid high in cycle 1.
- Sign fix-up (signed ops only):
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- W variants:
  - Operands are bits [31:0], signed or unsigned per op.
  - Result is sign-extended from bit 31.
- Special cases (RISC-V defined, no exception):
  - Divisor 0: quotient = all ones; remainder = dividend. For W: sign-extended dividend[31:0].
  - Signed overflow (most negative value / -1): quotient = dividend, remainder = 0.
  - W overflow result: 0xFFFFFFFF80000000.
- Flush:
  - flush=1 in any state: next state IDLE, div_valid=0 next cycle.
  - ex_stall_req forced 0 in that cycle.
  - flush has priority over a simultaneous div_req.
- rst mid-CALC: abort immediately; outputs return to reset values.
- div_req dropped during CALC is ignored; the operation completes. EX cannot change while stalled.

Optional Feature:
- Macro: DIV_RADIX4_EN.
- Defined:
  - Radix-4 iteration producing 2 quotient bits per cycle.
  - N = 32 (16 for W); all other timing rules unchanged.
- Undefined:
  - Radix-2, N = 64/32 as above.
- Results must be bit-identical in both builds.

Test Plan:
- DIV a=100, b=7, stall_ex mirrors ex_stall_req:
  - ex_stall_req high for 65 cycles; div_result=14, div_valid=1 in cycle 65.
  - Radix-4 build: 33 cycles.
- REM a=-7 (0xFFFFFFFFFFFFFFF9), b=2 -> div_result=0xFFFFFFFFFFFFFFFF (-1).
- DIVU a=5, b=0:
  - 1 stall cycle; div_result=0xFFFFFFFFFFFFFFFF in cycle 1.
- REMUW with b=0, a=0x00000000_80000001 -> div_result=0xFFFFFFFF80000001.
- DIVW a=0x80000000, b=0xFFFFFFFF -> div_result=0xFFFFFFFF80000000, 1 stall cycle.
- DIVU 10/3 with stall_ex held 1 for 5 extra cycles after completion:
  - div_valid=1 and div_result=3 held throughout.
  - Back to IDLE one cycle after stall_ex=0; no second stall request.
- flush at CALC cycle 20:
  - Next cycle IDLE, ex_stall_req=0, div_valid=0.
  - A following DIVU 9/3 returns 3 with full latency.
